// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS registers with byte strobes, read-only status registers and decode errors.
// Defining AXIL_REGBANK_WR_PULSE_EN adds a one-cycle per-register write pulse output (wr_pulse).
module axi4_lite_regbank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
`ifdef AXIL_REGBANK_WR_PULSE_EN
  output logic [NUM_REGS-1:0]            wr_pulse,
`endif
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in
);

  localparam int          STRB_W     = DATA_WIDTH / 8;
  localparam int          LSB        = $clog2(STRB_W);
  localparam int          IDX_W      = ADDR_WIDTH - LSB;
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic                  ready_en_reg;
  logic                  aw_latched_reg, w_latched_reg;
  logic [IDX_W-1:0]      awidx_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_W-1:0]     wstrb_reg;
  logic [1:0]            bresp_reg, rresp_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic                  aw_fire, w_fire, ar_fire;
  logic [31:0]           wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range, wr_ro, wr_err;
  logic [NUM_REGS-1:0]   wr_hit;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  unused_ok;

  // Byte-offset bits never take part in decode; reg_in is only consumed for RO slots.
  assign unused_ok = &{1'b0, s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0], reg_in};

  // Readies stay low until the first clock edge after reset is released.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en_reg <= 1'b0;
    else          ready_en_reg <= 1'b1;
  end

  assign s_axi_awready = ready_en_reg && (w_state_reg == W_IDLE) && !aw_latched_reg;
  assign s_axi_wready  = ready_en_reg && (w_state_reg == W_IDLE) && !w_latched_reg;
  assign s_axi_bvalid  = (w_state_reg == W_RESP);
  assign s_axi_bresp   = bresp_reg;
  assign aw_fire       = s_axi_awvalid && s_axi_awready;
  assign w_fire        = s_axi_wvalid && s_axi_wready;

  assign s_axi_arready = ready_en_reg && (r_state_reg == R_IDLE);
  assign s_axi_rvalid  = (r_state_reg == R_DATA);
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = rresp_reg;
  assign ar_fire       = s_axi_arvalid && s_axi_arready;

  assign wr_idx      = 32'(awidx_reg);
  assign rd_idx      = 32'(s_axi_araddr[ADDR_WIDTH-1:LSB]);
  assign wr_in_range = (wr_idx < NUM_REGS_U);
  assign rd_in_range = (rd_idx < NUM_REGS_U);
  assign wr_err      = !wr_in_range || wr_ro;

  always_comb begin
    wr_ro  = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == 32'(i)) wr_ro = RO_MASK[i];
      if (rd_idx == 32'(i)) rd_val = regs[i];
    end
  end

  // Write FSM
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_reg <= W_IDLE;
      r_state_reg <= R_IDLE;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:   if ((aw_latched_reg || aw_fire) && (w_latched_reg || w_fire)) w_state_next = W_COMMIT;
      W_COMMIT: w_state_next = W_RESP;
      W_RESP:   if (s_axi_bready) w_state_next = W_IDLE;
      default:  w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_latched_reg <= 1'b0;
      w_latched_reg  <= 1'b0;
      awidx_reg      <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      bresp_reg      <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_latched_reg <= 1'b1;
        awidx_reg      <= s_axi_awaddr[ADDR_WIDTH-1:LSB];
      end
      if (w_fire) begin
        w_latched_reg <= 1'b1;
        wdata_reg     <= s_axi_wdata;
        wstrb_reg     <= s_axi_wstrb;
      end
      if (w_state_reg == W_COMMIT) bresp_reg <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if ((w_state_reg == W_RESP) && s_axi_bready) begin
        aw_latched_reg <= 1'b0;
        w_latched_reg  <= 1'b0;
      end
    end
  end

  // Read FSM; data is captured at the AR handshake, so a same-cycle commit is not yet visible.
  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_fire) r_state_next = R_DATA;
      R_DATA:  if (s_axi_rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (ar_fire) begin
      rdata_reg <= rd_in_range ? rd_val : '0;
      rresp_reg <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Register storage: RO slots mirror reg_in, RW slots update per byte lane during W_COMMIT.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wr_hit[gi] = (w_state_reg == W_COMMIT) && (wr_idx == 32'(gi)) && !RO_MASK[gi];

      if (RO_MASK[gi]) begin : g_ro
        assign regs[gi] = reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] value_reg;
        always_ff @(posedge aclk or negedge aresetn) begin
          if (!aresetn) begin
            value_reg <= RESET_VAL;
          end else if (wr_hit[gi]) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wstrb_reg[b]) value_reg[b*8 +: 8] <= wdata_reg[b*8 +: 8];
            end
          end
        end
        assign regs[gi] = value_reg;
      end

      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
    end
  endgenerate

`ifdef AXIL_REGBANK_WR_PULSE_EN
  assign wr_pulse = wr_hit & {NUM_REGS{|wstrb_reg}};
`endif

endmodule

// File: doc/axi4_lite_regbank.md
Name: axi4_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank that generalises the single-register write/readback path into NUM_REGS registers.
- Adds byte-lane write strobes, read-only status registers, decode errors, and independent AW/W acceptance.
- Sits between the PS GP port (via interconnect) and dataplane control/status signals in the PL.
- Both bench and RTL use the existing axi_if write/read tasks.

Parameters:
DATA_WIDTH, 32, data bus width in bits; 32 or 64; byte-lane count = DATA_WIDTH/8.
ADDR_WIDTH, 12, address bus width in bits; must be ≥ log2(NUM_REGS*DATA_WIDTH/8).
NUM_REGS, 16, number of registers; 1..256.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from reg_in.
RESET_VAL, 0, reset value of every RW register.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  write byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
reg_in  in  NUM_REGS*DATA_WIDTH  status inputs for RO registers

Behaviour:
Reset (aresetn low, asynchronous):
- awready/wready/arready=0, bvalid/rvalid=0, bresp/rresp=0, rdata=0.
- RW registers = RESET_VAL; AW/W holding latches cleared.
- Reset mid-transaction aborts it with no response.
- Ready signals rise on the first aclk edge after deassertion.

Decode:
- index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits are ignored.
- index ≥ NUM_REGS → SLVERR (2'b10); otherwise OKAY (2'b00).

Write channel FSM (W_IDLE, W_COMMIT, W_RESP):
- W_IDLE:
  - awready=1 while no AW is latched; wready=1 while no W is latched.
  - AW and W may handshake in any order or in the same cycle; each is latched independently.
  - When both are latched, go to W_COMMIT.
- W_COMMIT (1 cycle):
  - Update byte lanes where wstrb=1; wstrb=0 lanes are unchanged.
  - Write to an RO or out-of-range register is dropped, bresp=SLVERR.
  - Assert bvalid; go to W_RESP.
- W_RESP:
  - Hold bvalid/bresp until bready; then clear latches and return to W_IDLE.
  - No new AW/W is accepted in W_COMMIT or W_RESP.
- Latency: both handshakes complete → bvalid 2 cycles later.

Read channel FSM (R_IDLE, R_DATA), independent of write:
- R_IDLE: arready=1. On AR handshake, capture rdata and rresp and assert rvalid next cycle.
  - rdata = reg_in slice for RO registers; register value for RW registers; 0 with SLVERR when out of range.
- R_DATA: arready=0; hold rvalid/rdata/rresp stable until rready; then return to R_IDLE.
  - Back-to-back reads achieve one beat per 2 cycles.

Boundary cases:
- AR handshake in the same cycle as W_COMMIT to the same register returns the pre-write value.
- The next read returns the new value.
- reg_out reflects a commit one cycle after W_COMMIT, i.e. on the edge that ends W_COMMIT.

Optional Feature:
AXIL_REGBANK_WR_PULSE_EN
- Defined: adds output wr_pulse [NUM_REGS].
  - Bit i is high for exactly one cycle, coincident with W_COMMIT, when RW register i is written with at least one strobe set.
  - Never pulses for RO, out-of-range, or all-zero-strobe writes.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then write 0xAAAAAAAA to 0x4 with wstrb=0xF; read 0x4 → rdata=0xAAAAAAAA, bresp=rresp=OKAY; all other registers read RESET_VAL.
2. Write 0xFFFFFFFF to 0x8, then write 0x12345678 with wstrb=0x5; read 0x8 → 0xFF34FF78.
3. Set RO_MASK bit 2 and reg_in slice 2 = 0xDEADBEEF; write 0x0 to 0x8 → bresp=SLVERR; read 0x8 → 0xDEADBEEF, OKAY.
4. Read and write to 0x40 with NUM_REGS=16 → rresp=SLVERR, rdata=0, bresp=SLVERR; no register changes.
5. Present W 3 cycles before AW, then hold bready/rready low for 5 cycles → bvalid/rvalid/data held stable; no second AW accepted until B completes.
6. Assert aresetn low mid W_RESP → bvalid=0 immediately; registers return to RESET_VAL; a fresh write/read sequence afterwards succeeds.
